// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage and the control FSM that drives it.
package fetch_pkg;

   localparam int INSTR_WIDTH = 16;
   localparam int DISP_WIDTH  = 8;

   // Next-PC select, also imported by the control FSM.
   typedef enum logic [1:0] {
      PC_INC    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_HOLD   = 2'b11
   } pc_state_e;

   // Fetch sequencer state encoding.
   typedef enum logic [1:0] {
      FETCH = 2'b00,
      LATCH = 2'b01,
      READY = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection; reused by later branch-predictor work.
module next_pc_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [1:0]            PCState,
   input  logic [DISP_WIDTH-1:0] BranchDisp,
   input  logic [ADDR_WIDTH-1:0] JumpTarget,
   output logic [ADDR_WIDTH-1:0] NextPC
);

   logic [ADDR_WIDTH-1:0] disp_sext;

   assign disp_sext = {{(ADDR_WIDTH-DISP_WIDTH){BranchDisp[DISP_WIDTH-1]}}, BranchDisp};

   // Select the next PC; all sums wrap modulo 2^ADDR_WIDTH.
   always_comb begin
      NextPC = PC;
      case (PCState)
         PC_INC:    NextPC = PC + ADDR_WIDTH'(1);
         PC_BRANCH: NextPC = PC + disp_sext;
         PC_JUMP:   NextPC = JumpTarget;
         PC_HOLD:   NextPC = PC;
         default:   NextPC = PC;
      endcase
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the one-cycle-latency
// instruction RAM and holds the fetched word until the control FSM
// commands the next PC update.
//
// state | meaning
// ------+--------------------------------------------------------------
// FETCH | address (=PC) presented to RAM with read enable
// LATCH | RAM data valid, captured into Instr on this edge
// READY | Instr/PC held and valid; PCEn selects next PC and refetches
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   PCEn,
   input  logic [1:0]             PCState,
   input  logic [DISP_WIDTH-1:0]  BranchDisp,
   input  logic [ADDR_WIDTH-1:0]  JumpTarget,
   input  logic [INSTR_WIDTH-1:0] MemData,
   output logic [ADDR_WIDTH-1:0]  MemAddr,
   output logic                   MemRdEn,
   output logic [INSTR_WIDTH-1:0] Instr,
   output logic                   InstrValid,
   output logic [ADDR_WIDTH-1:0]  PC,
   output logic [ADDR_WIDTH-1:0]  PCPlus1,
   output logic                   PCEnDropped
);

   fetch_state_e          state;
   fetch_state_e          state_nxt;
   logic                  pc_load;
   logic                  instr_load;
   logic                  drop_evt;
   logic [ADDR_WIDTH-1:0] pc_next;

   next_pc_calc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_next_pc_calc (
      .PC         (PC),
      .PCState    (PCState),
      .BranchDisp (BranchDisp),
      .JumpTarget (JumpTarget),
      .NextPC     (pc_next)
   );

   assign MemAddr = PC;
   assign PCPlus1 = PC + ADDR_WIDTH'(1);

   // Sequencer state register; reset discards any in-flight fetch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, strobes and Moore outputs.
   always_comb begin
      state_nxt  = state;
      pc_load    = 1'b0;
      instr_load = 1'b0;
      drop_evt   = 1'b0;
      MemRdEn    = 1'b0;
      InstrValid = 1'b0;
      case (state)
         FETCH: begin
            MemRdEn   = 1'b1;
            drop_evt  = PCEn;
            state_nxt = LATCH;
         end
         LATCH: begin
            instr_load = 1'b1;
            drop_evt   = PCEn;
            state_nxt  = READY;
         end
         READY: begin
            InstrValid = 1'b1;
            if (PCEn) begin
               pc_load   = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   // PC only moves when the control FSM's strobe is accepted in READY.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PC <= RESET_PC;
      end else if (pc_load) begin
         PC <= pc_next;
      end
   end

   // Capture the RAM word one cycle after its address was presented.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Instr <= '0;
      end else if (instr_load) begin
         Instr <= MemData;
      end
   end

   // Sticky flag: a PCEn arrived while the fetch was still in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PCEnDropped <= 1'b0;
      end else if (drop_evt) begin
         PCEnDropped <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: RAM model, cycle-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_inst_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        PCEn;
   logic [1:0]  PCState;
   logic [7:0]  BranchDisp;
   logic [15:0] JumpTarget;
   logic [15:0] MemData;
   logic [15:0] MemAddr;
   logic        MemRdEn;
   logic [15:0] Instr;
   logic        InstrValid;
   logic [15:0] PC;
   logic [15:0] PCPlus1;
   logic        PCEnDropped;

   int checks = 0;
   int errors = 0;

   inst_fetch_unit #(
      .ADDR_WIDTH (16),
      .RESET_PC   (16'h0000)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .PCEn        (PCEn),
      .PCState     (PCState),
      .BranchDisp  (BranchDisp),
      .JumpTarget  (JumpTarget),
      .MemData     (MemData),
      .MemAddr     (MemAddr),
      .MemRdEn     (MemRdEn),
      .Instr       (Instr),
      .InstrValid  (InstrValid),
      .PC          (PC),
      .PCPlus1     (PCPlus1),
      .PCEnDropped (PCEnDropped)
   );

   always #5 Clk = ~Clk;

   // RAM contents: word 0 fixed, everything else a distinct pattern.
   function automatic logic [15:0] ram_word(input logic [15:0] a);
      if (a == 16'h0000) return 16'h5103;
      return a ^ 16'hC3A5;
   endfunction

   // Synchronous RAM, one-cycle read latency.
   always @(posedge Clk) begin
      if (MemRdEn) MemData <= ram_word(MemAddr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: cycles remaining until the instruction is valid.
   int          m_busy;
   logic [15:0] m_pc;
   logic [15:0] m_instr;
   logic        m_dropped;

   function automatic logic [15:0] model_next(input logic [1:0] sel, input logic [15:0] pc,
                                              input logic [7:0] disp, input logic [15:0] tgt);
      int d;
      d = (disp >= 8'h80) ? int'(disp) - 256 : int'(disp);
      case (sel)
         2'b00:   return 16'((int'(pc) + 1) & 'hFFFF);
         2'b01:   return 16'((int'(pc) + d) & 'hFFFF);
         2'b10:   return tgt;
         default: return pc;
      endcase
   endfunction

   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         m_busy    = 2;
         m_pc      = 16'h0000;
         m_instr   = 16'h0000;
         m_dropped = 1'b0;
      end else if (m_busy > 0) begin
         if (PCEn) m_dropped = 1'b1;
         m_busy--;
         if (m_busy == 0) m_instr = ram_word(m_pc);
      end else if (PCEn) begin
         m_pc   = model_next(PCState, m_pc, BranchDisp, JumpTarget);
         m_busy = 2;
      end
   end

   // Every-cycle comparison against the model, away from the edge.
   always @(posedge Clk) begin
      #1;
      chk("m_valid",   InstrValid,  (m_busy == 0));
      chk("m_rden",    MemRdEn,     (m_busy == 2));
      chk("m_pc",      PC,          m_pc);
      chk("m_addr",    MemAddr,     m_pc);
      chk("m_pcplus1", PCPlus1,     16'(m_pc + 16'h0001));
      chk("m_instr",   Instr,       m_instr);
      chk("m_dropped", PCEnDropped, m_dropped);
   end

   // Issue one accepted PCEn from READY and check the 2-cycle bubble.
   task automatic issue(input logic [1:0] st, input logic [7:0] disp, input logic [15:0] tgt,
                        input string tag);
      @(negedge Clk);
      PCEn = 1'b1; PCState = st; BranchDisp = disp; JumpTarget = tgt;
      @(negedge Clk);
      PCEn = 1'b0;
      PCState = 2'($urandom_range(0, 3));
      BranchDisp = 8'($urandom);
      JumpTarget = 16'($urandom);
      chk({tag, "_valid_k"}, InstrValid, 1'b0);
      @(negedge Clk);
      chk({tag, "_valid_k1"}, InstrValid, 1'b0);
      @(negedge Clk);
      chk({tag, "_valid_k2"}, InstrValid, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; PCEn = 1'b0; PCState = 2'b00; BranchDisp = 8'h00; JumpTarget = 16'h0000;
      repeat (2) @(negedge Clk);
      chk("rst_valid",   InstrValid,  1'b0);
      chk("rst_rden",    MemRdEn,     1'b1);
      chk("rst_pc",      PC,          16'h0000);
      chk("rst_instr",   Instr,       16'h0000);
      chk("rst_dropped", PCEnDropped, 1'b0);
      Reset = 1'b0;

      @(negedge Clk);
      chk("boot_e1_valid", InstrValid, 1'b0);
      @(negedge Clk);
      chk("boot_e2_valid", InstrValid, 1'b1);
      chk("boot_instr",    Instr,      16'h5103);
      chk("boot_pc",       PC,         16'h0000);
      chk("boot_pcplus1",  PCPlus1,    16'h0001);

      // Hold in READY: nothing moves without PCEn.
      repeat (3) @(negedge Clk);
      chk("idle_pc", PC, 16'h0000);

      issue(2'b10, 8'h00, 16'hFFFF, "jmp_ffff");
      chk("jmp_ffff_instr", Instr, 16'h3C5A);
      chk("jmp_ffff_pcp1",  PCPlus1, 16'h0000);
      issue(2'b00, 8'h00, 16'h0000, "inc_wrap");
      chk("inc_wrap_pc",    PC,    16'h0000);
      chk("inc_wrap_instr", Instr, 16'h5103);

      issue(2'b10, 8'h00, 16'h0002, "jmp_0002");
      issue(2'b01, 8'hFC, 16'h0000, "br_neg");
      chk("br_neg_pc",    PC,    16'hFFFE);
      chk("br_neg_instr", Instr, 16'h3C5B);

      issue(2'b10, 8'h00, 16'h0010, "jmp_0010");
      issue(2'b01, 8'h7F, 16'h0000, "br_pos");
      chk("br_pos_pc",    PC,    16'h008F);
      chk("br_pos_instr", Instr, 16'hC32A);

      issue(2'b10, 8'h00, 16'h1234, "jmp_1234");
      chk("jmp_1234_pc",    PC,    16'h1234);
      chk("jmp_1234_instr", Instr, 16'hD191);
      issue(2'b11, 8'h55, 16'hAAAA, "hold");
      chk("hold_pc",    PC,    16'h1234);
      chk("hold_instr", Instr, 16'hD191);

      // PCEn pulsed during LATCH of an INC fetch.
      @(negedge Clk);
      PCEn = 1'b1; PCState = 2'b00;
      @(negedge Clk);
      PCEn = 1'b0;
      @(negedge Clk);
      chk("drop_in_latch_rden", MemRdEn, 1'b0);
      PCEn = 1'b1; PCState = 2'b10; JumpTarget = 16'h7777;
      @(negedge Clk);
      PCEn = 1'b0;
      chk("drop_pc",      PC,          16'h1235);
      chk("drop_instr",   Instr,       16'hD190);
      chk("drop_valid",   InstrValid,  1'b1);
      chk("drop_flag",    PCEnDropped, 1'b1);
      issue(2'b00, 8'h00, 16'h0000, "after_drop");
      chk("after_drop_pc",   PC,          16'h1236);
      chk("after_drop_flag", PCEnDropped, 1'b1);

      // Reset asserted while LATCH of PC=0040.
      @(negedge Clk);
      PCEn = 1'b1; PCState = 2'b10; JumpTarget = 16'h0040;
      @(negedge Clk);
      PCEn = 1'b0;
      @(negedge Clk);
      chk("pre_rst_pc",   PC,      16'h0040);
      chk("pre_rst_rden", MemRdEn, 1'b0);
      #2 Reset = 1'b1;
      #1;
      chk("async_rst_valid",   InstrValid,  1'b0);
      chk("async_rst_pc",      PC,          16'h0000);
      chk("async_rst_rden",    MemRdEn,     1'b1);
      chk("async_rst_instr",   Instr,       16'h0000);
      chk("async_rst_dropped", PCEnDropped, 1'b0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk("rerun_e1_valid", InstrValid, 1'b0);
      @(negedge Clk);
      chk("rerun_e2_valid", InstrValid, 1'b1);
      chk("rerun_instr",    Instr,      16'h5103);
      chk("rerun_pc",       PC,         16'h0000);

      repeat (2) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
